// File: rtl/pc_gen_pkg.sv
// Shared front-end definitions: fetch packet layout toward the backend queue.
// Latency: n/a (type and constant definitions only).
// Backpressure: n/a.
package pc_gen_pkg;

    localparam int vaddr_width_gp = 39;
    localparam int instr_width_gp = 32;

    typedef enum logic [1:0] {
        e_fe_msg_fetch     = 2'b00,
        e_fe_msg_exception = 2'b01,
        e_fe_msg_itlb_miss = 2'b10,
        e_fe_msg_reserved  = 2'b11
    } bp_fe_msg_type_e;

    // One fetch packet as handed from pc_gen to the backend queue
    typedef struct packed {
        bp_fe_msg_type_e             msg_type;
        logic [vaddr_width_gp-1:0]   pc;
        logic [instr_width_gp-1:0]   instr;
    } bp_fe_queue_s;

    localparam int bp_fe_queue_width = $bits(bp_fe_queue_s);

endpackage

// File: rtl/bp_fe_queue_ptr.sv
// Circular pointer with wrap bit: index in the low bits, lap parity in the MSB.
// Latency: new value one cycle after inc_i/clear_i; reset is immediate.
// Backpressure: none; the caller decides when to increment.
module bp_fe_queue_ptr #(
    parameter int els_p = 8
) (
    input  logic                   clk_i,
    input  logic                   reset_n_i,
    input  logic                   clear_i,
    input  logic                   inc_i,
    output logic [$clog2(els_p):0] ptr_o
);

    localparam int ptr_w = $clog2(els_p) + 1;

    // Natural overflow of an index+wrap register gives modulo 2*els_p counting;
    // clear takes priority so a flush always lands both pointers on zero
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            ptr_o <= '0;
        end else if (clear_i) begin
            ptr_o <= '0;
        end else if (inc_i) begin
            ptr_o <= ptr_o + ptr_w'(1);
        end
    end

endmodule

// File: rtl/bp_fe_queue_buffer.sv
// Front-end fetch packet buffer between pc_gen and the backend, els_p deep.
// Latency: one cycle enqueue-to-output (no bypass); count updates next cycle.
// Backpressure: ready = not full (and not flushing); a dequeue frees a slot only next cycle.
module bp_fe_queue_buffer
    import pc_gen_pkg::*;
#(
    parameter int els_p            = 8,
    parameter int fe_queue_width_p = bp_fe_queue_width
) (
    input  logic                        clk_i,
    input  logic                        reset_n_i,
    input  logic                        flush_i,
    input  logic [fe_queue_width_p-1:0] fe_queue_i,
    input  logic                        fe_queue_v_i,
    output logic                        fe_queue_ready_o,
    output logic [fe_queue_width_p-1:0] fe_queue_o,
    output logic                        fe_queue_v_o,
    input  logic                        fe_queue_yumi_i,
    output logic [$clog2(els_p):0]      count_o
);

    // els_p must be a power of two >= 2 so pointer overflow wraps at 2*els_p
    localparam int idx_w = $clog2(els_p);
    localparam int ptr_w = idx_w + 1;

    logic [ptr_w-1:0]            wr_ptr;
    logic [ptr_w-1:0]            rd_ptr;
    logic                        empty;
    logic                        full;
    logic                        enq;
    logic                        deq;
    logic [fe_queue_width_p-1:0] mem [els_p];

    // Equal pointers mean empty; equal indices on different laps mean full
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[idx_w-1:0] == rd_ptr[idx_w-1:0]) &&
                   (wr_ptr[idx_w] != rd_ptr[idx_w]);

    // Ready deliberately ignores yumi so the producer never sees a comb path
    // from the backend; flush blocks the producer for that cycle
    assign fe_queue_ready_o = !full && !flush_i;
    assign fe_queue_v_o     = !empty;
    assign count_o          = wr_ptr - rd_ptr;

    // Transfers in a flush cycle are dropped; the empty guard keeps an
    // illegal yumi from corrupting the pointers
    assign enq = fe_queue_v_i && fe_queue_ready_o;
    assign deq = fe_queue_yumi_i && !empty && !flush_i;

    bp_fe_queue_ptr #(
        .els_p (els_p)
    ) u_wr_ptr (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .clear_i   (flush_i),
        .inc_i     (enq),
        .ptr_o     (wr_ptr)
    );

    bp_fe_queue_ptr #(
        .els_p (els_p)
    ) u_rd_ptr (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .clear_i   (flush_i),
        .inc_i     (deq),
        .ptr_o     (rd_ptr)
    );

    // Storage write port; contents are never cleared, pointers alone mark validity
    always_ff @(posedge clk_i) begin
        if (enq) begin
            mem[wr_ptr[idx_w-1:0]] <= fe_queue_i;
        end
    end

    // Read port: oldest entry straight from the array, no bypass from the input
    assign fe_queue_o = mem[rd_ptr[idx_w-1:0]];

endmodule

// File: tb/tb_bp_fe_queue_buffer.sv
module tb_bp_fe_queue_buffer;
    import pc_gen_pkg::*;

    localparam int ELS = 8;
    localparam int W   = bp_fe_queue_width;
    localparam int CW  = $clog2(ELS) + 1;

    logic          clk_i = 1'b0;
    logic          reset_n_i;
    logic          flush_i;
    logic [W-1:0]  fe_queue_i;
    logic          fe_queue_v_i;
    logic          fe_queue_ready_o;
    logic [W-1:0]  fe_queue_o;
    logic          fe_queue_v_o;
    logic          fe_queue_yumi_i;
    logic [CW-1:0] count_o;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] sb [$];

    typedef struct {
        logic         v;
        logic [W-1:0] d;
        logic         yumi;
        int           exp_cnt;
        logic         exp_rdy;
    } vec_t;

    vec_t tbl [$];

    bp_fe_queue_buffer #(
        .els_p            (ELS),
        .fe_queue_width_p (W)
    ) dut (
        .clk_i            (clk_i),
        .reset_n_i        (reset_n_i),
        .flush_i          (flush_i),
        .fe_queue_i       (fe_queue_i),
        .fe_queue_v_i     (fe_queue_v_i),
        .fe_queue_ready_o (fe_queue_ready_o),
        .fe_queue_o       (fe_queue_o),
        .fe_queue_v_o     (fe_queue_v_o),
        .fe_queue_yumi_i  (fe_queue_yumi_i),
        .count_o          (count_o)
    );

    always #5 clk_i = ~clk_i;

    // yumi without valid output is an illegal backend request
    always @(posedge clk_i) begin
        if (reset_n_i) begin
            assert (!(fe_queue_yumi_i && !fe_queue_v_o))
                else $error("FAIL illegal_yumi actual=1 required=0");
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Drive one cycle, check outputs against the scoreboard before the edge,
    // update the scoreboard with the transfers the model says happen
    task automatic step(input logic v, input logic [W-1:0] d, input logic y, input logic f);
        logic mrdy;
        fe_queue_v_i    = v;
        fe_queue_i      = d;
        fe_queue_yumi_i = y;
        flush_i         = f;
        #1;
        mrdy = (sb.size() < ELS) && !f;
        chk("ready", fe_queue_ready_o, mrdy);
        chk("valid", fe_queue_v_o, sb.size() != 0);
        chk("count", count_o, sb.size());
        if (sb.size() != 0) chk("data", fe_queue_o, sb[0]);
        if (f) begin
            sb.delete();
        end else begin
            if (y && sb.size() != 0) void'(sb.pop_front());
            if (v && mrdy) sb.push_back(d);
        end
        @(posedge clk_i);
        #1;
    endtask

    function automatic vec_t mk(input logic v, input int d, input logic y, input int c, input logic r);
        vec_t t;
        t.v = v; t.d = W'(d); t.yumi = y; t.exp_cnt = c; t.exp_rdy = r;
        return t;
    endfunction

    initial begin
        reset_n_i       = 1'b0;
        flush_i         = 1'b0;
        fe_queue_i      = '0;
        fe_queue_v_i    = 1'b0;
        fe_queue_yumi_i = 1'b0;

        // Fill to full, blocked 0x9 while draining one, 0x9 accepted, drain all
        for (int i = 0; i < 8; i++) tbl.push_back(mk(1'b1, i + 1, 1'b0, i + 1, i < 7));
        tbl.push_back(mk(1'b1, 9, 1'b1, 7, 1'b1));
        tbl.push_back(mk(1'b1, 9, 1'b0, 8, 1'b0));
        for (int i = 0; i < 8; i++) tbl.push_back(mk(1'b0, 0, 1'b1, 7 - i, 1'b1));

        #3;
        chk("rst_valid", fe_queue_v_o, 1'b0);
        chk("rst_ready", fe_queue_ready_o, 1'b1);
        chk("rst_count", count_o, 0);
        #9 reset_n_i = 1'b1;
        @(posedge clk_i);
        #1;

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].v, tbl[i].d, tbl[i].yumi, 1'b0);
            chk($sformatf("tbl%0d_cnt", i), count_o, tbl[i].exp_cnt);
            chk($sformatf("tbl%0d_rdy", i), fe_queue_ready_o, tbl[i].exp_rdy);
        end

        // Streaming: 20 packets, dequeue every cycle after the first
        step(1'b1, W'(32'h100), 1'b0, 1'b0);
        for (int i = 1; i < 20; i++) begin
            step(1'b1, W'(32'h100 + i), 1'b1, 1'b0);
            chk("stream_cnt", count_o, 1);
        end
        step(1'b0, '0, 1'b1, 1'b0);
        chk("stream_empty", count_o, 0);

        // Flush with 5 entries, concurrent enqueue of 0xA and yumi
        for (int i = 0; i < 5; i++) step(1'b1, W'(32'h20 + i), 1'b0, 1'b0);
        step(1'b1, W'(32'hA), 1'b1, 1'b1);
        chk("flush_cnt", count_o, 0);
        chk("flush_valid", fe_queue_v_o, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);
        step(1'b1, W'(32'hB), 1'b0, 1'b0);
        chk("post_flush_data", fe_queue_o, W'(32'hB));
        step(1'b0, '0, 1'b1, 1'b0);

        // Async reset pulse between edges with 3 entries
        for (int i = 0; i < 3; i++) step(1'b1, W'(32'h30 + i), 1'b0, 1'b0);
        chk("pre_rst_cnt", count_o, 3);
        fe_queue_v_i = 1'b0;
        reset_n_i    = 1'b0;
        #1;
        chk("async_rst_valid", fe_queue_v_o, 1'b0);
        chk("async_rst_cnt", count_o, 0);
        chk("async_rst_ready", fe_queue_ready_o, 1'b1);
        #1 reset_n_i = 1'b1;
        sb.delete();
        @(posedge clk_i);
        #1;

        // Enqueue 0x5 into empty buffer: visible exactly one cycle later
        step(1'b1, W'(32'h5), 1'b0, 1'b0);
        chk("n1_valid", fe_queue_v_o, 1'b1);
        chk("n1_data", fe_queue_o, W'(32'h5));
        chk("n1_cnt", count_o, 1);
        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
